// File: rtl/i2c_init_sequencer_if.sv
// Command/data stream bundle between the init sequencer and the i2c_master core.
// The sequencer side uses the master modport; the i2c_master core (or a bench
// model of it) uses the slave modport.
interface i2c_init_sequencer_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_read;
  logic       cmd_write;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       data_in_last;
  logic       i2c_busy;
  logic       missed_ack;

  modport master (
    output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop,
    output cmd_valid, data_in, data_in_valid, data_in_last,
    input  cmd_ready, data_in_ready, i2c_busy, missed_ack
  );

  modport slave (
    input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop,
    input  cmd_valid, data_in, data_in_valid, data_in_last,
    output cmd_ready, data_in_ready, i2c_busy, missed_ack
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Table-driven I2C register-write sequencer for power-up configuration.
// Walks a synchronous ROM of {end, device, register, value} words and issues
// one write transaction (address, register byte, value byte, STOP) per entry.
//
// Optional feature: define I2C_INIT_RETRY_EN to retry an entry up to MAX_RETRY
// extra times after a missed ACK, with GAP_CYCLES idle cycles before each retry.
// Without it, a missed ACK aborts immediately and no retry/gap counters exist.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | rom_addr presented, waiting one cycle of ROM latency
// CHECK  | latch entry, clear ack flag; end marker -> DONE
// CMD    | cmd_valid held until cmd_ready
// DATA0  | register byte held until data_in_ready
// DATA1  | value byte (last) held until data_in_ready
// WAIT   | at least 2 cycles, then wait for master idle
// EVAL   | next entry, retry or abort depending on ack flag
// RETRY  | idle gap before re-issuing the same entry (retry build only)
// DONE   | one-cycle done pulse
// ERROR  | record failing index, set sticky error
module i2c_init_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     err_index,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [23:0]           rom_data,
  i2c_init_sequencer_if.master  i2c
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CHECK, S_CMD, S_DATA0, S_DATA1,
    S_WAIT, S_EVAL, S_RETRY, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   err_index_q, err_index_d;
  logic                error_q, error_d;
  logic [22:0]         entry_q, entry_d;
  logic                nack_q, nack_d;
  logic                wait_cnt_q, wait_cnt_d;

`ifdef I2C_INIT_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
`endif

  // Next-state and datapath updates; every _d defaults to its flop.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    err_index_d = err_index_q;
    error_d     = error_q;
    entry_d     = entry_q;
    nack_d      = nack_q;
    wait_cnt_d  = wait_cnt_q;
`ifdef I2C_INIT_RETRY_EN
    retry_d     = retry_q;
    gap_d       = gap_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
          error_d    = 1'b0;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        entry_d = rom_data[22:0];
        nack_d  = 1'b0;
`ifdef I2C_INIT_RETRY_EN
        retry_d = '0;
`endif
        state_d = rom_data[23] ? S_DONE : S_CMD;
      end
      S_CMD: begin
        if (i2c.cmd_ready) state_d = S_DATA0;
      end
      S_DATA0: begin
        if (i2c.data_in_ready) state_d = S_DATA1;
      end
      S_DATA1: begin
        if (i2c.data_in_ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = 1'b1;
        end
      end
      S_WAIT: begin
        // the master may not have raised busy yet; give it two cycles first
        if (wait_cnt_q != 1'b0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end else if (!i2c.i2c_busy) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!nack_q) begin
          // last table slot without an end marker finishes instead of wrapping
          if (rom_addr_q == {ADDR_W{1'b1}}) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = S_FETCH;
          end
        end else begin
`ifdef I2C_INIT_RETRY_EN
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = S_RETRY;
          end else begin
            state_d = S_ERROR;
          end
`else
          state_d = S_ERROR;
`endif
        end
      end
      S_RETRY: begin
`ifdef I2C_INIT_RETRY_EN
        if (gap_q == '0) begin
          retry_d = retry_q + 1'b1;
          nack_d  = 1'b0;
          state_d = S_CMD;
        end else begin
          gap_d = gap_q - 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: state_d = S_IDLE;
      S_ERROR: begin
        error_d     = 1'b1;
        err_index_d = rom_addr_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // missed ACK anywhere in the transaction window marks the entry failed
    if (i2c.missed_ack && (state_q == S_CMD || state_q == S_DATA0 ||
                           state_q == S_DATA1 || state_q == S_WAIT)) begin
      nack_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      err_index_q <= '0;
      error_q     <= 1'b0;
      entry_q     <= '0;
      nack_q      <= 1'b0;
      wait_cnt_q  <= 1'b0;
`ifdef I2C_INIT_RETRY_EN
      retry_q     <= '0;
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      err_index_q <= err_index_d;
      error_q     <= error_d;
      entry_q     <= entry_d;
      nack_q      <= nack_d;
      wait_cnt_q  <= wait_cnt_d;
`ifdef I2C_INIT_RETRY_EN
      retry_q     <= retry_d;
      gap_q       <= gap_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign err_index = err_index_q;
  assign rom_addr  = rom_addr_q;

  // Command flags are only meaningful with cmd_valid; gating them keeps every
  // output at 0 in reset while presenting write_multiple+stop with each command.
  assign i2c.cmd_valid          = (state_q == S_CMD);
  assign i2c.cmd_address        = entry_q[22:16];
  assign i2c.cmd_start          = 1'b0;
  assign i2c.cmd_read           = 1'b0;
  assign i2c.cmd_write          = 1'b0;
  assign i2c.cmd_write_multiple = (state_q == S_CMD);
  assign i2c.cmd_stop           = (state_q == S_CMD);

  assign i2c.data_in_valid = (state_q == S_DATA0) || (state_q == S_DATA1);
  assign i2c.data_in_last  = (state_q == S_DATA1);
  assign i2c.data_in       = (state_q == S_DATA1) ? entry_q[7:0] : entry_q[15:8];

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: tests push expected transactions and
// end events into queues; a negedge monitor pops and compares as the DUT emits.
module tb_i2c_init_sequencer;
  localparam int ADDR_W   = 8;
  localparam int GAP      = 1000;
  localparam int END_DONE = -1;
`ifdef I2C_INIT_RETRY_EN
  localparam int ATTEMPTS = 4;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, start;
  logic              busy, done, error;
  logic [ADDR_W-1:0] err_index, rom_addr;
  logic [23:0]       rom_data;
  logic [23:0]       rom [0:(1<<ADDR_W)-1];

  i2c_init_sequencer_if bus();

  i2c_init_sequencer #(.ADDR_W(ADDR_W), .MAX_RETRY(3), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data), .i2c(bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [22:0] exp_txn[$];
  int          exp_end[$];
  int unsigned t_start[$];
  int unsigned t_end[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string info);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, info);
  endtask

  // ---------------- master model ----------------
  int   cmd_stall = 0, byte_stall = 0;
  int   nack_entry = -1, nack_count = 0, nack_seen = 0;
  bit   nack_now;
  int   ccnt, dcnt, tail;
  logic m_cv, m_dv, m_dl, hs_c, hs_d;
  logic [7:0] m_ra;

  initial begin
    bus.cmd_ready = 0; bus.data_in_ready = 0; bus.i2c_busy = 0; bus.missed_ack = 0;
    ccnt = 0; dcnt = 0; tail = 0; nack_now = 0; m_cv = 0; m_dv = 0; m_dl = 0; m_ra = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.cmd_ready = 0; bus.data_in_ready = 0; bus.i2c_busy = 0; bus.missed_ack = 0;
        ccnt = 0; dcnt = 0; tail = 0; nack_now = 0; m_cv = 0; m_dv = 0; m_dl = 0;
      end else begin
        hs_c = m_cv && bus.cmd_ready;
        hs_d = m_dv && bus.data_in_ready;
        bus.missed_ack = 0;
        if (hs_c) begin
          bus.i2c_busy = 1;
          ccnt = 0;
          nack_now = (int'(m_ra) == nack_entry) && (nack_seen < nack_count);
          if (int'(m_ra) == nack_entry) nack_seen++;
        end
        if (hs_d) dcnt = 0;
        if (hs_d && m_dl) tail = 6;
        else if (tail > 0) begin
          tail--;
          if (tail == 3 && nack_now) bus.missed_ack = 1;
          if (tail == 0) bus.i2c_busy = 0;
        end
        if (bus.cmd_valid) begin
          if (ccnt >= cmd_stall) bus.cmd_ready = 1;
          else begin bus.cmd_ready = 0; ccnt++; end
        end else begin
          bus.cmd_ready = 0; ccnt = 0;
        end
        if (bus.data_in_valid) begin
          if (dcnt >= byte_stall) bus.data_in_ready = 1;
          else begin bus.data_in_ready = 0; dcnt++; end
        end else begin
          bus.data_in_ready = 0; dcnt = 0;
        end
        m_cv = bus.cmd_valid; m_dv = bus.data_in_valid; m_dl = bus.data_in_last; m_ra = rom_addr;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        pv_cv, pv_cr, pv_dv, pv_dr, pv_dl, pv_err;
  logic [6:0]  pv_ca, cur_dev;
  logic [7:0]  pv_d, cur_reg;
  logic [22:0] e_txn;
  int          nb, e_end;

  always @(negedge clk) begin
    if (rst) begin
      nb = 0; pv_cv = 0; pv_cr = 0; pv_dv = 0; pv_dr = 0; pv_dl = 0; pv_err = 0;
      pv_ca = 0; pv_d = 0;
    end else begin
      if (pv_cv && !pv_cr) begin
        chk("cmd_valid_hold", bus.cmd_valid, 1);
        chk("cmd_addr_stable", bus.cmd_address, pv_ca);
      end
      if (pv_dv && !pv_dr)
        chk("data_stable", {bus.data_in_valid, bus.data_in_last, bus.data_in}, {1'b1, pv_dl, pv_d});
      if (bus.cmd_valid && !pv_cv) t_start.push_back(cyc);
      if (bus.cmd_valid && bus.cmd_ready) begin
        chk("cmd_flags", {bus.cmd_start, bus.cmd_read, bus.cmd_write, bus.cmd_write_multiple, bus.cmd_stop}, 5'b00011);
        chk("cmd_mid_txn", nb, 0);
        cur_dev = bus.cmd_address;
        nb = 1;
      end
      if (bus.data_in_valid && bus.data_in_ready) begin
        if (nb == 1) begin
          chk("byte0_last", bus.data_in_last, 0);
          cur_reg = bus.data_in;
          nb = 2;
        end else if (nb == 2) begin
          chk("byte1_last", bus.data_in_last, 1);
          t_end.push_back(cyc);
          nb = 0;
          if (exp_txn.size() == 0)
            fail_msg("txn_unexpected", $sformatf("got 0x%0h expected none", {cur_dev, cur_reg, bus.data_in}));
          else begin
            e_txn = exp_txn.pop_front();
            chk("txn", {cur_dev, cur_reg, bus.data_in}, e_txn);
          end
        end else begin
          fail_msg("byte_without_cmd", $sformatf("got byte 0x%0h expected none", bus.data_in));
        end
      end
      if (done) begin
        if (exp_end.size() == 0) fail_msg("done_unexpected", "got done expected none");
        else begin
          e_end = exp_end.pop_front();
          chk("end_is_done", END_DONE, e_end);
        end
      end
      if (error && !pv_err) begin
        if (exp_end.size() == 0) fail_msg("error_unexpected", $sformatf("got error idx %0d expected none", err_index));
        else begin
          e_end = exp_end.pop_front();
          chk("end_err_index", err_index, e_end);
        end
      end
      pv_cv = bus.cmd_valid; pv_cr = bus.cmd_ready; pv_ca = bus.cmd_address;
      pv_dv = bus.data_in_valid; pv_dr = bus.data_in_ready; pv_dl = bus.data_in_last;
      pv_d = bus.data_in; pv_err = error;
    end
  end

  // ---------------- helpers ----------------
  task automatic fill_end();
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 24'h800000;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    if (busy) fail_msg({name, "_timeout"}, $sformatf("busy still 1 after %0d cycles, expected 0", budget));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_addr(input string name, input logic [ADDR_W-1:0] a, input int budget);
    int n = 0;
    while (rom_addr !== a && n < budget) begin @(negedge clk); n++; end
    if (rom_addr !== a) fail_msg({name, "_timeout"}, $sformatf("rom_addr 0x%0h expected 0x%0h", rom_addr, a));
  endtask

  task automatic chk_queues(input string name);
    chk({name, "_txn_left"}, exp_txn.size(), 0);
    chk({name, "_end_left"}, exp_end.size(), 0);
  endtask

  task automatic push_rom(input int idx);
    exp_txn.push_back(rom[idx][22:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    rst = 1; start = 0;
    fill_end();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {busy, done, error, bus.cmd_valid, bus.data_in_valid, bus.data_in_last}, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_err_index", err_index, 0);
    chk("rst_payload", {bus.cmd_address, bus.data_in}, 0);
    @(posedge clk); #1; rst = 0;

    // basic writes, start timing, ignored start
    fill_end();
    rom[0] = 24'h4C10AA; rom[1] = 24'h4C1155;
    push_rom(0); push_rom(1); exp_end.push_back(END_DONE);
    pulse_start();
    @(negedge clk); chk("t1_busy_c1", busy, 1);
    @(negedge clk); chk("t1_cmdv_c2", bus.cmd_valid, 0);
    @(negedge clk); chk("t1_cmdv_c3", bus.cmd_valid, 1);
    chk("t1_cmd_addr", bus.cmd_address, 7'h4C);
    wait_addr("t1_addr1", 1, 200);
    pulse_start();
    @(negedge clk);
    chk("t1_ignored_start_addr", rom_addr, 1);
    chk("t1_ignored_start_busy", busy, 1);
    wait_idle("t1", 300);
    chk("t1_error", error, 0);
    chk_queues("t1");

    // empty table
    fill_end();
    exp_end.push_back(END_DONE);
    pulse_start();
    @(negedge clk); chk("t2_c1", {busy, done}, 2'b10);
    @(negedge clk); chk("t2_c2", {busy, done}, 2'b10);
    @(negedge clk); chk("t2_c3", {busy, done}, 2'b11);
    @(negedge clk); chk("t2_c4", {busy, done}, 2'b00);
    chk_queues("t2");

    // backpressure
    fill_end();
    rom[0] = 24'h1A2001; rom[1] = 24'h2BFE80;
    push_rom(0); push_rom(1); exp_end.push_back(END_DONE);
    cmd_stall = 10; byte_stall = 5;
    pulse_start();
    wait_idle("t3", 500);
    cmd_stall = 0; byte_stall = 0;
    chk("t3_error", error, 0);
    chk_queues("t3");

    // single missed ACK on entry 1
    fill_end();
    rom[0] = 24'h300102; rom[1] = 24'h310304; rom[2] = 24'h320506;
    nack_entry = 1; nack_count = 1; nack_seen = 0;
    t_start.delete(); t_end.delete();
`ifdef I2C_INIT_RETRY_EN
    push_rom(0); push_rom(1); push_rom(1); push_rom(2); exp_end.push_back(END_DONE);
`else
    push_rom(0); push_rom(1); exp_end.push_back(1);
`endif
    pulse_start();
    wait_idle("t4", 5000);
`ifdef I2C_INIT_RETRY_EN
    chk("t4_error", error, 0);
    if (t_start.size() >= 3 && t_end.size() >= 2)
      chk("t4_retry_gap_ge_1000", (t_start[2] - t_end[1]) >= GAP, 1);
    else
      fail_msg("t4_retry_records", $sformatf("got %0d starts expected >=3", t_start.size()));
`else
    chk("t4_error", {error, err_index}, {1'b1, 8'd1});
`endif
    chk_queues("t4");

    // persistent NACK on entry 2
    fill_end();
    rom[0] = 24'h400010; rom[1] = 24'h410020; rom[2] = 24'h420030; rom[3] = 24'h430040;
    nack_entry = 2; nack_count = 100; nack_seen = 0;
    push_rom(0); push_rom(1);
    for (int k = 0; k < ATTEMPTS; k++) push_rom(2);
    exp_end.push_back(2);
    pulse_start();
    wait_idle("t5", 10000);
    chk("t5_error", error, 1);
    chk("t5_err_index", err_index, 2);
    chk("t5_attempts", nack_seen, ATTEMPTS);
    chk_queues("t5");

    // new start clears error
    nack_entry = -1;
    fill_end();
    rom[0] = 24'h4C10AA; rom[1] = 24'h4C1155;
    push_rom(0); push_rom(1); exp_end.push_back(END_DONE);
    pulse_start();
    @(negedge clk); chk("t6_error_cleared", error, 0);
    wait_idle("t6", 300);
    chk_queues("t6");

    // reset during DATA0
    byte_stall = 5;
    pulse_start();
    begin
      int n = 0;
      while (!(bus.data_in_valid && !bus.data_in_last) && n < 100) begin @(negedge clk); n++; end
      if (!(bus.data_in_valid && !bus.data_in_last)) fail_msg("t7_data0_timeout", "DATA0 not reached");
    end
    @(posedge clk); #1; rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_rst_ctrl", {busy, done, error, bus.cmd_valid, bus.data_in_valid, bus.data_in_last}, 0);
    chk("t7_rst_rom_addr", rom_addr, 0);
    chk("t7_rst_payload", {bus.cmd_address, bus.data_in}, 0);
    @(posedge clk); #1; rst = 0;
    byte_stall = 0;
    exp_txn.delete(); exp_end.delete();
    push_rom(0); push_rom(1); exp_end.push_back(END_DONE);
    pulse_start();
    wait_idle("t7", 300);
    chk("t7_error", error, 0);
    chk_queues("t7");

    // full table without end marker: finishes at last slot, no wrap
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      logic [7:0] b;
      b = i[7:0];
      rom[i] = {1'b0, 7'h50, b, ~b};
      push_rom(i);
    end
    exp_end.push_back(END_DONE);
    pulse_start();
    wait_idle("t8", 20000);
    chk("t8_rom_addr_last", rom_addr, 8'hFF);
    chk("t8_error", error, 0);
    chk_queues("t8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
